// File: rtl/alu_multicycle.sv
// Integer ALU with single-cycle arithmetic, logic and shift ops plus iterative carry-less multiply.
// Latency: 1 cycle for ops 0-7 and reserved opcodes; XLEN/BITS_PER_CYCLE + 1 cycles for CLMUL/CLMULH/CLMULR.
// Backpressure: valid/ready on both sides; the result is held while the consumer stalls, and new requests are refused until it drains.
module alu_multicycle #(
    parameter int XLEN           = 64,
    parameter int TRANS_ID_BITS  = 3,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [3:0]               operator_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int SHW   = $clog2(XLEN);
    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SLL    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_CLMUL  = 4'd8;
    localparam logic [3:0] OP_CLMULH = 4'd9;
    localparam logic [3:0] OP_CLMULR = 4'd10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state;
    logic [CNT_W-1:0]           iter_cnt;
    logic [2*XLEN-1:0]          acc;
    logic [2*XLEN-1:0]          acc_nxt;
    logic [2*XLEN-1:0]          a_sh;
    logic [XLEN-1:0]            b_sh;
    logic [3:0]                 op_q;
    logic [TRANS_ID_BITS-1:0]   tag_q;
    logic [XLEN-1:0]            alu_res;
    logic [XLEN-1:0]            clmul_res;
    logic [SHW-1:0]             shamt;
    logic                       is_clmul;

    // Reset gates ready so nothing is offered upstream while the unit is held in reset.
    assign ready_o = rst_ni && (state == IDLE) && (!valid_o || ready_i) && !flush_i;

    assign shamt    = operand_b_i[SHW-1:0];
    assign is_clmul = (operator_i == OP_CLMUL) || (operator_i == OP_CLMULH) ||
                      (operator_i == OP_CLMULR);

    always_comb begin
        alu_res = '0;
        case (operator_i)
            OP_ADD:  alu_res = operand_a_i + operand_b_i;
            OP_SUB:  alu_res = operand_a_i - operand_b_i;
            OP_AND:  alu_res = operand_a_i & operand_b_i;
            OP_OR:   alu_res = operand_a_i | operand_b_i;
            OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
            OP_SLL:  alu_res = operand_a_i << shamt;
            OP_SRL:  alu_res = operand_a_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand_a_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration folds BITS_PER_CYCLE partial products of the shifted multiplicand.
    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_sh[j]) begin
                acc_nxt = acc_nxt ^ (a_sh << j);
            end
        end
    end

    // The top product bit is always zero, so CLMULR's window ends one bit short of the top.
    always_comb begin
        clmul_res = acc_nxt[XLEN-1:0];
        case (op_q)
            OP_CLMULH: clmul_res = acc_nxt[2*XLEN-1:XLEN];
            OP_CLMULR: clmul_res = acc_nxt[2*XLEN-2:XLEN-1];
            default:   clmul_res = acc_nxt[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            iter_cnt   <= '0;
            acc        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            valid_o    <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
        end else if (flush_i) begin
            state    <= IDLE;
            iter_cnt <= '0;
            valid_o  <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        if (is_clmul) begin
                            state    <= BUSY;
                            iter_cnt <= '0;
                            acc      <= '0;
                            a_sh     <= {{XLEN{1'b0}}, operand_a_i};
                            b_sh     <= operand_b_i;
                            op_q     <= operator_i;
                            tag_q    <= trans_id_i;
                        end else begin
                            valid_o    <= 1'b1;
                            result_o   <= alu_res;
                            trans_id_o <= trans_id_i;
                        end
                    end
                end
                BUSY: begin
                    acc      <= acc_nxt;
                    a_sh     <= a_sh << BITS_PER_CYCLE;
                    b_sh     <= b_sh >> BITS_PER_CYCLE;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    // Final iteration lands straight in the output register.
                    if (iter_cnt == LAST_ITER) begin
                        state      <= IDLE;
                        iter_cnt   <= '0;
                        valid_o    <= 1'b1;
                        result_o   <= clmul_res;
                        trans_id_o <= tag_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized bench for alu_multicycle against a plain-arithmetic reference model.
// Latency: checks 1-cycle and iterative paths; a second instance covers 8 bits per cycle.
// Backpressure: exercises consumer stalls, flush and mid-operation reset.
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  tag_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result;
    logic [2:0]  tag_o;

    logic        flush8;
    logic        valid8_i;
    logic        ready8_o;
    logic [3:0]  op8;
    logic [63:0] a8;
    logic [63:0] b8;
    logic [2:0]  tag8_i;
    logic        valid8_o;
    logic        ready8_i;
    logic [63:0] result8;
    logic [2:0]  tag8_o;

    int n_checks = 0;
    int n_pass   = 0;

    alu_multicycle #(.XLEN(64), .TRANS_ID_BITS(3), .BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
        .operator_i(op), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tag_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result), .trans_id_o(tag_o)
    );

    alu_multicycle #(.XLEN(64), .TRANS_ID_BITS(3), .BITS_PER_CYCLE(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush8), .valid_i(valid8_i), .ready_o(ready8_o),
        .operator_i(op8), .operand_a_i(a8), .operand_b_i(b8), .trans_id_i(tag8_i),
        .valid_o(valid8_o), .ready_i(ready8_i), .result_o(result8), .trans_id_o(tag8_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        logic [63:0]  r;
        int           s;
        p = '0;
        r = '0;
        s = int'(y[5:0]);
        for (int i = 0; i < 64; i++) begin
            if (y[i]) p = p ^ ({64'd0, x} << i);
        end
        case (o)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = x << s;
            4'd6:  r = x >> s;
            4'd7:  begin
                r = x >> s;
                for (int i = 0; i < 64; i++) if (x[63] && i >= 64 - s) r[i] = 1'b1;
            end
            4'd8:  r = p[63:0];
            4'd9:  r = p[127:64];
            4'd10: r = p[126:63];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_one(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                           input logic [2:0] t, output logic [63:0] r, output logic [2:0] rt,
                           output int lat, output bit leak);
        int w;
        @(negedge clk);
        valid_i = 1'b1; op = o; a = x; b = y; tag_i = t; ready_i = 1'b1;
        w = 0;
        while (!ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        leak = 1'b0;
        while (!valid_o && lat < 200) begin
            if (ready_o) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!valid_o) lat = -1;
        r = result;
        rt = tag_o;
    endtask

    task automatic run_one8(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                            input logic [2:0] t, output logic [63:0] r, output int lat);
        int w;
        @(negedge clk);
        valid8_i = 1'b1; op8 = o; a8 = x; b8 = y; tag8_i = t;
        w = 0;
        while (!ready8_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        valid8_i = 1'b0;
        lat = 1;
        while (!valid8_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!valid8_o) lat = -1;
        r = result8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
        n_checks++; if (tag_o !== 3'd0) $display("FAIL reset_tag: got %0d want 0", tag_o); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL release_ready: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_add_wrap();
        valid_i = 1'b1; op = 4'd0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; tag_i = 3'd5; ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL add_wrap_valid: got %b want 1", valid_o); else n_pass++;
        n_checks++; if (result !== 64'd0) $display("FAIL add_wrap_result: got %h want 0", result); else n_pass++;
        n_checks++; if (tag_o !== 3'd5) $display("FAIL add_wrap_tag: got %0d want 5", tag_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) $display("FAIL add_wrap_drain: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [2:0]  tag_q[$];
        logic [3:0]  o;
        logic [63:0] e;
        logic [2:0]  et;
        ready_i = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                et = tag_q.pop_front();
                n_checks++; if (valid_o !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_o); else n_pass++;
                n_checks++; if (result !== e) $display("FAIL b2b_result[%0d] op %0d: got %h want %h", i, op, result, e); else n_pass++;
                n_checks++; if (tag_o !== et) $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, tag_o, et); else n_pass++;
            end
            if (i < 40) begin
                o = 4'($urandom_range(0, 12));
                if (o > 4'd7) o = o + 4'd3;
                valid_i = 1'b1; op = o; a = rnd64(); b = rnd64(); tag_i = 3'($urandom_range(0, 7));
                if (i % 5 == 0) b = 64'(i + 1);
                #1;
                n_checks++; if (ready_o !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready_o); else n_pass++;
                exp_q.push_back(model(op, a, b));
                tag_q.push_back(tag_i);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (valid_o !== 1'b0) $display("FAIL b2b_drain: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_clmul();
        logic [63:0] r;
        logic [63:0] x;
        logic [63:0] y;
        logic [3:0]  o;
        logic [2:0]  rt;
        int          lat;
        bit          leak;
        run_one(4'd8, 64'd3, 64'd3, 3'd2, r, rt, lat, leak);
        n_checks++; if (r !== 64'd5) $display("FAIL clmul_3x3: got %h want 5", r); else n_pass++;
        n_checks++; if (lat != 65) $display("FAIL clmul_latency: got %0d want 65", lat); else n_pass++;
        n_checks++; if (leak) $display("FAIL clmul_busy_ready: got 1 want 0"); else n_pass++;
        n_checks++; if (rt !== 3'd2) $display("FAIL clmul_tag: got %0d want 2", rt); else n_pass++;
        run_one(4'd9, 64'h8000_0000_0000_0000, 64'd2, 3'd4, r, rt, lat, leak);
        n_checks++; if (r !== 64'd1) $display("FAIL clmulh_edge: got %h want 1", r); else n_pass++;
        run_one(4'd10, 64'h8000_0000_0000_0000, 64'd2, 3'd4, r, rt, lat, leak);
        n_checks++; if (r !== 64'd2) $display("FAIL clmulr_edge: got %h want 2", r); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            o = 4'(8 + (i % 3));
            x = rnd64();
            y = rnd64();
            run_one(o, x, y, 3'(i), r, rt, lat, leak);
            n_checks++; if (r !== model(o, x, y)) $display("FAIL clmul_rand[%0d] op %0d: got %h want %h", i, o, r, model(o, x, y)); else n_pass++;
            n_checks++; if (lat != 65) $display("FAIL clmul_rand_lat[%0d]: got %0d want 65", i, lat); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1; op = 4'd7; a = 64'h8000_0000_0000_0000; b = 64'd63; tag_i = 3'd3;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (valid_o !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, valid_o); else n_pass++;
            n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL bp_result[%0d]: got %h want ffffffffffffffff", i, result); else n_pass++;
            n_checks++; if (tag_o !== 3'd3) $display("FAIL bp_tag[%0d]: got %0d want 3", i, tag_o); else n_pass++;
            n_checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_o); else n_pass++;
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL bp_ready_release: got %b want 1", ready_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) $display("FAIL bp_drain: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_flush();
        logic [63:0] r;
        logic [2:0]  rt;
        int          lat;
        bit          leak;
        bit          seen;
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b1; op = 4'd8; a = rnd64() | 64'd1; b = rnd64() | 64'd1; tag_i = 3'd6;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", ready_o); else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (valid_o) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen) $display("FAIL flush_no_result: got valid want none"); else n_pass++;
        flush = 1'b1;
        valid_i = 1'b1; op = 4'd0; a = 64'd7; b = 64'd8; tag_i = 3'd7;
        #1;
        n_checks++; if (ready_o !== 1'b0) $display("FAIL flush_prio_ready: got %b want 0", ready_o); else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL flush_prio_valid: got %b want 0", valid_o); else n_pass++;
        run_one(4'd0, 64'd2, 64'd3, 3'd1, r, rt, lat, leak);
        n_checks++; if (r !== 64'd5) $display("FAIL flush_then_add: got %h want 5", r); else n_pass++;
        n_checks++; if (lat != 1) $display("FAIL flush_then_add_lat: got %0d want 1", lat); else n_pass++;
        n_checks++; if (rt !== 3'd1) $display("FAIL flush_then_add_tag: got %0d want 1", rt); else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b1; op = 4'd9; a = rnd64(); b = rnd64(); tag_i = 3'd2;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (ready_o !== 1'b0) $display("FAIL midbusy_ready: got %b want 0", ready_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL async_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (result !== 64'd0) $display("FAIL async_result: got %h want 0", result); else n_pass++;
        n_checks++; if (tag_o !== 3'd0) $display("FAIL async_tag: got %0d want 0", tag_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b0) $display("FAIL async_ready: got %b want 0", ready_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1; op = 4'd1; a = 64'd10; b = 64'd12; tag_i = 3'd4;
        #1;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", ready_o); else n_pass++;
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL post_reset_valid: got %b want 1", valid_o); else n_pass++;
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL post_reset_sub: got %h want fffffffffffffffe", result); else n_pass++;
    endtask

    task automatic test_bpc8();
        logic [63:0] r;
        logic [63:0] x;
        logic [63:0] y;
        logic [3:0]  o;
        int          lat;
        run_one8(4'd9, 64'h8000_0000_0000_0000, 64'd2, 3'd1, r, lat);
        n_checks++; if (r !== 64'd1) $display("FAIL bpc8_clmulh: got %h want 1", r); else n_pass++;
        n_checks++; if (lat != 9) $display("FAIL bpc8_clmulh_lat: got %0d want 9", lat); else n_pass++;
        run_one8(4'd10, 64'h8000_0000_0000_0000, 64'd2, 3'd2, r, lat);
        n_checks++; if (r !== 64'd2) $display("FAIL bpc8_clmulr: got %h want 2", r); else n_pass++;
        n_checks++; if (lat != 9) $display("FAIL bpc8_clmulr_lat: got %0d want 9", lat); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            o = 4'(8 + (i % 3));
            x = rnd64();
            y = rnd64();
            run_one8(o, x, y, 3'(i), r, lat);
            n_checks++; if (r !== model(o, x, y)) $display("FAIL bpc8_rand[%0d] op %0d: got %h want %h", i, o, r, model(o, x, y)); else n_pass++;
            n_checks++; if (lat != 9) $display("FAIL bpc8_rand_lat[%0d]: got %0d want 9", i, lat); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; op = '0; a = '0; b = '0; tag_i = '0; ready_i = 1'b1;
        flush8 = 1'b0; valid8_i = 1'b0; op8 = '0; a8 = '0; b8 = '0; tag8_i = '0; ready8_i = 1'b1;
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_clmul();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        test_bpc8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
